// File: rtl/procyon_wb_pkg.sv
// Shared Wishbone B4 constants for the procyon system bus: signal widths,
// cycle type identifiers and burst type encodings.
package procyon_wb_pkg;

  localparam int WB_CTI_WIDTH = 3;
  localparam int WB_BTE_WIDTH = 2;

  // Cycle type identifiers
  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_INCR    = 3'b010;
  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [WB_BTE_WIDTH-1:0] WB_BTE_LINEAR = 2'b00;

endpackage

// File: rtl/ic_wb_fetch.sv
// Instruction fetch engine. Turns the core's fetch request into read-only
// Wishbone B4 transfers. One 32-bit instruction is one or two bus beats,
// depending on the bus width. A one-entry buffer answers repeat fetches of
// the same PC without touching the bus.
module ic_wb_fetch
  import procyon_wb_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_INSN_WIDTH    = 32,
  parameter int OPTN_WB_DATA_WIDTH = 32   // 16 or 32
) (
  input  logic                            clk,
  input  logic                            n_rst,

  // Core fetch port
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_ic_pc,
  input  logic                            i_ic_en,
  output logic [OPTN_INSN_WIDTH-1:0]      o_ic_insn,
  output logic                            o_ic_valid,

  // Wishbone B4 master (read only)
  input  logic                            i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb_data,
  output logic                            o_wb_cyc,
  output logic                            o_wb_stb,
  output logic                            o_wb_we,
  output logic [WB_CTI_WIDTH-1:0]         o_wb_cti,
  output logic [WB_BTE_WIDTH-1:0]         o_wb_bte,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [OPTN_ADDR_WIDTH-1:0]      o_wb_addr
);

  localparam int BEATS        = OPTN_INSN_WIDTH / OPTN_WB_DATA_WIDTH;
  localparam int WB_DATA_SIZE = OPTN_WB_DATA_WIDTH / 8;

  localparam logic [OPTN_ADDR_WIDTH-1:0] ALIGN_MASK  = ~OPTN_ADDR_WIDTH'(3);
  localparam logic [OPTN_ADDR_WIDTH-1:0] ADDR_STRIDE = OPTN_ADDR_WIDTH'(WB_DATA_SIZE);

  // The first beat of a multi-beat fetch is an incrementing burst beat.
  // A single-beat fetch is a classic cycle.
  localparam logic [WB_CTI_WIDTH-1:0] FIRST_CTI = (BEATS == 1) ? WB_CTI_CLASSIC : WB_CTI_INCR;

  typedef enum logic {
    IDLE,
    BUS
  } state_t;

  state_t                       state;
  logic                         beat;        // index of the beat in flight
  logic [OPTN_ADDR_WIDTH-1:0]   req_pc;      // aligned PC of the fetch on the bus
  logic                         buf_valid;
  logic [OPTN_ADDR_WIDTH-1:0]   buf_pc;
  logic [OPTN_INSN_WIDTH-1:0]   buf_insn;
  logic [OPTN_INSN_WIDTH-1:0]   asm_next;    // instruction word once this beat lands

  logic [OPTN_ADDR_WIDTH-1:0]   aligned_pc;
  logic                         hit;
  logic                         last_beat;
  logic                         miss_start;
  logic                         bus_ack;
  logic                         last_ack;
  logic                         deliver;

  // Constant bus signals: a read-only master on a linear burst.
  assign o_wb_we  = 1'b0;
  assign o_wb_bte = WB_BTE_LINEAR;
  assign o_wb_sel = '1;

  assign aligned_pc = i_ic_pc & ALIGN_MASK;
  assign hit        = buf_valid && (aligned_pc == buf_pc);
  assign last_beat  = (beat == 1'(BEATS - 1));
  assign miss_start = (state == IDLE) && i_ic_en && !hit;

  // An ack is honoured only inside a burst. A late ack that reaches an idle
  // master, e.g. after a reset mid-burst, is dropped here.
  assign bus_ack  = (state == BUS) && i_wb_ack;
  assign last_ack = bus_ack && last_beat;

  // The finished word goes to the core only if the core still wants this PC.
  // If the core redirected during the burst, the word is only buffered.
  assign deliver = last_ack && i_ic_en && (aligned_pc == req_pc);

  // Instruction assembly. A 32-bit bus delivers the word in one beat.
  // A 16-bit bus delivers it in two beats, little-endian: the low half first.
  if (BEATS == 1) begin : g_single
    assign asm_next = OPTN_INSN_WIDTH'(i_wb_data);
  end else begin : g_pair
    logic [OPTN_INSN_WIDTH-1:0] asm_q;

    // Merge the incoming half-word into the partial word.
    always_comb begin
      // NOTE: assign a default first so that every path drives asm_next.
      // Without it, a partial assignment would infer a latch.
      asm_next = asm_q;
      if (beat) asm_next[OPTN_INSN_WIDTH-1:OPTN_WB_DATA_WIDTH] = i_wb_data;
      else      asm_next[OPTN_WB_DATA_WIDTH-1:0]               = i_wb_data;
    end

    // Keep the partial word between beats.
    always_ff @(posedge clk) begin
      if (bus_ack) asm_q <= asm_next;
    end
  end

  // Datapath registers: the request PC and the instruction buffer contents.
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. buf_valid qualifies them, and
    // buf_valid is reset in the control block below.
    if (miss_start) req_pc <= aligned_pc;
    if (last_ack) begin
      buf_pc   <= req_pc;
      buf_insn <= asm_next;
    end
  end

  // Fetch FSM together with every registered core-side and bus-side output.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then updates from the values it had before the edge.
      state      <= IDLE;
      beat       <= 1'b0;
      buf_valid  <= 1'b0;
      o_ic_valid <= 1'b0;
      o_ic_insn  <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_cti   <= WB_CTI_CLASSIC;
    end else begin
      o_ic_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_ic_en) begin
            if (hit) begin
              o_ic_valid <= 1'b1;
              o_ic_insn  <= buf_insn;
            end else begin
              beat      <= 1'b0;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_addr <= aligned_pc;
              o_wb_cti  <= FIRST_CTI;
              state     <= BUS;
            end
          end
        end

        BUS: begin
          if (i_wb_ack) begin
            if (last_beat) begin
              beat      <= 1'b0;
              buf_valid <= 1'b1;
              o_wb_cyc  <= 1'b0;
              o_wb_stb  <= 1'b0;
              o_wb_cti  <= WB_CTI_CLASSIC;
              state     <= IDLE;
              if (deliver) begin
                o_ic_valid <= 1'b1;
                o_ic_insn  <= asm_next;
              end
            end else begin
              // Only two-beat fetches get here, so the next beat is the last.
              beat      <= beat + 1'b1;
              o_wb_addr <= o_wb_addr + ADDR_STRIDE;
              o_wb_cti  <= WB_CTI_EOB;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Bus protocol checks: cyc and stb move together, and a strobed beat
  // holds its address and cycle type until it is acknowledged.
  a_cyc_stb : assert property (@(posedge clk) disable iff (!n_rst)
    o_wb_cyc == o_wb_stb);

  a_stb_hold : assert property (@(posedge clk) disable iff (!n_rst)
    (o_wb_stb && !i_wb_ack) |=> (o_wb_stb && $stable(o_wb_addr) && $stable(o_wb_cti)));

endmodule

// File: tb/tb_ic_wb_fetch.sv
// Bench for ic_wb_fetch. It instantiates one 16-bit bus DUT, which runs two
// beats per instruction, and one 32-bit bus DUT, which runs a single beat.
// The stimulus pushes the expected bus beats and instructions into queues.
// Monitors pop and compare those entries whenever the DUT presents a beat or
// an instruction.
module tb_ic_wb_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;

  // 16-bit data bus DUT
  logic [31:0] pc16;
  logic        en16;
  logic [31:0] insn16;
  logic        valid16;
  logic        ack16;
  logic        stray_ack;
  logic [15:0] data16;
  logic [15:0] stray_data;
  logic        cyc16, stb16, we16;
  logic [2:0]  cti16;
  logic [1:0]  bte16;
  logic [1:0]  sel16;
  logic [31:0] addr16;

  // 32-bit data bus DUT
  logic [31:0] pc32;
  logic        en32;
  logic [31:0] insn32;
  logic        valid32;
  logic        ack32;
  logic [31:0] data32;
  logic        cyc32, stb32, we32;
  logic [2:0]  cti32;
  logic [1:0]  bte32;
  logic [3:0]  sel32;
  logic [31:0] addr32;

  ic_wb_fetch #(.OPTN_WB_DATA_WIDTH(16)) dut16 (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_ic_pc    (pc16),
    .i_ic_en    (en16),
    .o_ic_insn  (insn16),
    .o_ic_valid (valid16),
    .i_wb_ack   (ack16 | stray_ack),
    .i_wb_data  (stray_ack ? stray_data : data16),
    .o_wb_cyc   (cyc16),
    .o_wb_stb   (stb16),
    .o_wb_we    (we16),
    .o_wb_cti   (cti16),
    .o_wb_bte   (bte16),
    .o_wb_sel   (sel16),
    .o_wb_addr  (addr16)
  );

  ic_wb_fetch #(.OPTN_WB_DATA_WIDTH(32)) dut32 (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_ic_pc    (pc32),
    .i_ic_en    (en32),
    .o_ic_insn  (insn32),
    .o_ic_valid (valid32),
    .i_wb_ack   (ack32),
    .i_wb_data  (data32),
    .o_wb_cyc   (cyc32),
    .o_wb_stb   (stb32),
    .o_wb_we    (we32),
    .o_wb_cti   (cti32),
    .o_wb_bte   (bte32),
    .o_wb_sel   (sel32),
    .o_wb_addr  (addr32)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  cti;
  } beat_t;

  beat_t       beat_q16[$];
  beat_t       beat_q32[$];
  logic [31:0] insn_q16[$];
  logic [31:0] insn_q32[$];

  // Slave memory contents, as 16-bit and 32-bit words.
  function automatic logic [15:0] mem16(input logic [31:0] a);
    case (a)
      32'h100: return 16'h1234;
      32'h102: return 16'hABCD;
      32'h200: return 16'h1111;
      32'h202: return 16'h2222;
      32'h300: return 16'h3333;
      32'h302: return 16'h4444;
      32'h400: return 16'h7777;
      32'h402: return 16'h8888;
      32'h500: return 16'h5555;
      32'h502: return 16'h6666;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [31:0] mem32(input logic [31:0] a);
    if (a == 32'h104) return 32'hDEADBEEF;
    return 32'h0;
  endfunction

  // Wishbone slaves. Each one acks after a programmable number of wait
  // states, and its inputs change #1 after the clock edge.
  int waits16 = 0;
  int cnt16   = 0;
  initial begin
    ack16  = 1'b0;
    data16 = '0;
    forever begin
      @(posedge clk); #1;
      ack16 = 1'b0;
      if (cyc16 && stb16) begin
        if (cnt16 >= waits16) begin
          ack16  = 1'b1;
          data16 = mem16(addr16);
          cnt16  = 0;
        end else begin
          cnt16++;
        end
      end else begin
        cnt16 = 0;
      end
    end
  end

  initial begin
    ack32  = 1'b0;
    data32 = '0;
    forever begin
      @(posedge clk); #1;
      ack32 = 1'b0;
      if (cyc32 && stb32) begin
        ack32  = 1'b1;
        data32 = mem32(addr32);
      end
    end
  end

  // Monitors. They sample on the falling edge, away from the active edge.
  beat_t       exp_beat16, exp_beat32;
  logic [31:0] exp_insn16, exp_insn32;

  always @(negedge clk) begin
    if (cyc16 && stb16 && ack16) begin
      if (beat_q16.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut16 beat: unexpected beat at addr 0x%0h", addr16);
      end else begin
        exp_beat16 = beat_q16.pop_front();
        check("dut16 beat addr", addr16, exp_beat16.addr);
        check("dut16 beat cti", cti16, exp_beat16.cti);
        check("dut16 beat sel", sel16, 2'b11);
        check("dut16 beat we", we16, 1'b0);
        check("dut16 beat bte", bte16, 2'b00);
      end
    end
    if (valid16) begin
      if (insn_q16.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut16 valid: unexpected pulse with insn 0x%0h", insn16);
      end else begin
        exp_insn16 = insn_q16.pop_front();
        check("dut16 insn", insn16, exp_insn16);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc32 && stb32 && ack32) begin
      if (beat_q32.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut32 beat: unexpected beat at addr 0x%0h", addr32);
      end else begin
        exp_beat32 = beat_q32.pop_front();
        check("dut32 beat addr", addr32, exp_beat32.addr);
        check("dut32 beat cti", cti32, exp_beat32.cti);
        check("dut32 beat sel", sel32, 4'hF);
        check("dut32 beat we", we32, 1'b0);
        check("dut32 beat bte", bte32, 2'b00);
      end
    end
    if (valid32) begin
      if (insn_q32.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut32 valid: unexpected pulse with insn 0x%0h", insn32);
      end else begin
        exp_insn32 = insn_q32.pop_front();
        check("dut32 insn", insn32, exp_insn32);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Bounded waits. Each returns the number of edges it waited, and a
  // timeout counts as a failed comparison.
  task automatic wait_valid16(input string name, output int n);
    n = 0;
    while (!valid16 && n < 100) begin step(); n++; end
    check({name, " valid arrived"}, valid16, 1'b1);
  endtask

  task automatic wait_valid32(input string name, output int n);
    n = 0;
    while (!valid32 && n < 100) begin step(); n++; end
    check({name, " valid arrived"}, valid32, 1'b1);
  endtask

  task automatic wait_cyc16(input logic level, input string name);
    int n = 0;
    while (cyc16 !== level && n < 100) begin step(); n++; end
    check({name, " cyc level"}, cyc16, level);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int lat;
  int gap;

  initial begin
    n_rst      = 1'b0;
    pc16       = '0;
    en16       = 1'b0;
    pc32       = '0;
    en32       = 1'b0;
    stray_ack  = 1'b0;
    stray_data = '0;
    repeat (3) step();

    // Reset state
    check("rst valid16", valid16, 1'b0);
    check("rst cyc16", cyc16, 1'b0);
    check("rst stb16", stb16, 1'b0);
    check("rst insn16", insn16, 32'h0);
    check("rst addr16", addr16, 32'h0);
    check("rst cti16", cti16, 3'b000);
    check("rst valid32", valid32, 1'b0);
    check("rst cyc32", cyc32, 1'b0);
    check("rst addr32", addr32, 32'h0);
    n_rst = 1'b1;
    step();

    // Miss on 0x100, two zero-wait beats, expected word 0xABCD1234
    waits16 = 0;
    beat_q16.push_back('{addr: 32'h100, cti: 3'b010});
    beat_q16.push_back('{addr: 32'h102, cti: 3'b111});
    insn_q16.push_back(32'hABCD1234);
    pc16 = 32'h100;
    en16 = 1'b1;
    wait_valid16("miss 0x100", lat);
    check("miss 0x100 latency", lat, 3);
    en16 = 1'b0;
    step();
    check("miss 0x100 single pulse", valid16, 1'b0);

    // Repeated fetch of 0x100 hits the buffer every cycle it is held
    for (int i = 0; i < 4; i++) insn_q16.push_back(32'hABCD1234);
    en16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hit 0x100 valid", valid16, 1'b1);
      check("hit 0x100 no bus", cyc16, 1'b0);
    end
    en16 = 1'b0;
    step();
    check("hit 0x100 stops", valid16, 1'b0);

    // Miss on 0x200 with 3 wait states; the core drops en during the burst
    waits16 = 3;
    beat_q16.push_back('{addr: 32'h200, cti: 3'b010});
    beat_q16.push_back('{addr: 32'h202, cti: 3'b111});
    pc16 = 32'h200;
    en16 = 1'b1;
    wait_cyc16(1'b1, "redirect 0x200 start");
    en16 = 1'b0;
    wait_cyc16(1'b0, "redirect 0x200 end");
    step();
    check("redirect 0x200 no valid", valid16, 1'b0);

    // The result for 0x200 was buffered, so it is now a hit
    insn_q16.push_back(32'h22221111);
    en16 = 1'b1;
    step();
    check("buffered 0x200 hit", valid16, 1'b1);
    check("buffered 0x200 no bus", cyc16, 1'b0);
    en16 = 1'b0;
    step();

    // Miss on 0x500; the core switches to 0x300 mid-burst. The 0x300 burst
    // follows after exactly one idle cycle and is delivered.
    beat_q16.push_back('{addr: 32'h500, cti: 3'b010});
    beat_q16.push_back('{addr: 32'h502, cti: 3'b111});
    beat_q16.push_back('{addr: 32'h300, cti: 3'b010});
    beat_q16.push_back('{addr: 32'h302, cti: 3'b111});
    insn_q16.push_back(32'h44443333);
    pc16 = 32'h500;
    en16 = 1'b1;
    wait_cyc16(1'b1, "switch 0x500 start");
    pc16 = 32'h300;
    wait_cyc16(1'b0, "switch 0x500 end");
    gap = 0;
    while (!cyc16 && gap < 20) begin step(); gap++; end
    check("idle gap between bursts", gap, 1);
    wait_valid16("switch 0x300", lat);
    en16 = 1'b0;
    step();
    check("switch 0x300 single pulse", valid16, 1'b0);

    // Misaligned PC on the 32-bit bus: a single classic read at 0x104
    beat_q32.push_back('{addr: 32'h104, cti: 3'b000});
    insn_q32.push_back(32'hDEADBEEF);
    pc32 = 32'h106;
    en32 = 1'b1;
    wait_valid32("misaligned 0x106", lat);
    check("misaligned 0x106 latency", lat, 2);
    en32 = 1'b0;
    step();
    check("misaligned single pulse", valid32, 1'b0);

    // Reset during beat 1 of a burst for 0x400
    beat_q16.push_back('{addr: 32'h400, cti: 3'b010});
    pc16 = 32'h400;
    en16 = 1'b1;
    lat = 0;
    while (!(cyc16 && addr16 == 32'h402) && lat < 100) begin step(); lat++; end
    check("reset test reached beat 1", addr16, 32'h402);
    n_rst = 1'b0;
    en16  = 1'b0;
    step();
    check("mid-burst reset cyc", cyc16, 1'b0);
    check("mid-burst reset stb", stb16, 1'b0);
    check("mid-burst reset valid", valid16, 1'b0);
    check("mid-burst reset addr", addr16, 32'h0);
    n_rst = 1'b1;
    step();
    stray_data = 16'hBEEF;
    stray_ack  = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    step();
    check("stale ack no bus", cyc16, 1'b0);
    check("stale ack no valid", valid16, 1'b0);

    // The buffer was invalidated by the reset, so 0x300 misses again
    waits16 = 0;
    beat_q16.push_back('{addr: 32'h300, cti: 3'b010});
    beat_q16.push_back('{addr: 32'h302, cti: 3'b111});
    insn_q16.push_back(32'h44443333);
    pc16 = 32'h300;
    en16 = 1'b1;
    step();
    check("post-reset 0x300 no hit", valid16, 1'b0);
    check("post-reset 0x300 bus", cyc16, 1'b1);
    wait_valid16("post-reset 0x300", lat);
    en16 = 1'b0;
    step();

    repeat (3) step();
    check("dut16 beats left", beat_q16.size(), 0);
    check("dut16 insns left", insn_q16.size(), 0);
    check("dut32 beats left", beat_q32.size(), 0);
    check("dut32 insns left", insn_q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ic_wb_fetch.md
# ic_wb_fetch

Instruction fetch engine that replaces the simulation-only instruction port on the `procyon` top. It consumes the core's fetch request (`o_ic_pc`/`o_ic_en`) and drives `i_ic_insn`/`i_ic_valid` back to the core. It fetches each instruction over a read-only Wishbone B4 master port toward `sram_wb`, through the system Wishbone arbiter. A one-entry instruction buffer serves repeated fetches of the same PC without bus traffic.

## Interface
- `OPTN_ADDR_WIDTH`, 32: PC and Wishbone address width.
- `OPTN_INSN_WIDTH`, 32: instruction width; fixed at 32.
- `OPTN_WB_DATA_WIDTH`, 32: Wishbone data width; legal values 16 or 32.
- `clk`  in  1  sole clock; Wishbone runs on it.
- `n_rst`  in  1  reset; synchronous, active-low.
- `i_ic_pc`  in  `OPTN_ADDR_WIDTH`  fetch address from the core.
- `i_ic_en`  in  1  fetch request.
- `o_ic_insn`  out  32  fetched instruction.
- `o_ic_valid`  out  1  one-cycle pulse qualifying `o_ic_insn`.
- `i_wb_ack`  in  1  slave acknowledge.
- `i_wb_data`  in  `OPTN_WB_DATA_WIDTH`  read data.
- `o_wb_cyc`, `o_wb_stb`  out  1  bus cycle and strobe.
- `o_wb_we`  out  1  tied 0.
- `o_wb_cti`  out  3  cycle type identifier.
- `o_wb_bte`  out  2  burst type; tied 2'b00 (linear).
- `o_wb_sel`  out  `OPTN_WB_DATA_WIDTH/8`  byte selects; all ones.
- `o_wb_addr`  out  `OPTN_ADDR_WIDTH`  beat address.

## Operation
- `BEATS` = 32 / `OPTN_WB_DATA_WIDTH` (1 or 2). `WB_DATA_SIZE` = `OPTN_WB_DATA_WIDTH/8`.
- Request address = `i_ic_pc` with bits [1:0] forced to 0.
- Buffer holds `buf_valid`, `buf_pc`, `buf_insn`.
- A hit means `buf_valid` is set and the aligned `i_ic_pc` equals `buf_pc`.
- FSM state IDLE:
  - `i_ic_en` and hit: next cycle `o_ic_valid`=1 and `o_ic_insn`=`buf_insn`; stay in IDLE. Holding the same PC yields a valid pulse every cycle.
  - `i_ic_en` and miss: latch `req_pc`, set the beat counter to 0, go to BUS.
  - No `i_ic_en`: `o_ic_valid`=0.
- FSM state BUS:
  - `o_wb_cyc` = `o_wb_stb` = 1.
  - `o_wb_addr` = `req_pc` + beat × `WB_DATA_SIZE`.
  - `o_wb_cti` = 3'b000 when `BEATS`=1. When `BEATS`=2 it is 3'b010 on beat 0 and 3'b111 on the last beat.
  - Each `i_wb_ack` stores `i_wb_data` into the assembly register, little-endian (beat 0 goes to bits [15:0]), and increments the beat counter.
  - On the last ack:
    - Drop `cyc`/`stb` next cycle.
    - Write the buffer: `buf_pc` ← `req_pc`, `buf_insn` ← assembled word, `buf_valid` ← 1.
    - Return to IDLE.
    - In the cycle after the last ack, `o_ic_valid` is asserted with the new instruction only if, in the ack cycle, `i_ic_en`=1 and the aligned `i_ic_pc` = `req_pc`. Otherwise the result is only buffered (core redirected).
- A PC change or `i_ic_en` drop during BUS does not abort the burst; the request completes.
- The cycle after returning to IDLE, a new miss is evaluated normally, giving one idle bus cycle between bursts.
- A request seen in IDLE is never dropped. A held `i_ic_en` re-evaluates each IDLE cycle.

## Timing
- Reset (`n_rst`=0 at a clock edge) forces the following, all registered:
  - FSM to IDLE.
  - `o_ic_valid`, `o_wb_cyc`, `o_wb_stb` to 0.
  - `o_ic_insn`, `o_wb_addr` and the beat counter to 0.
  - `o_wb_cti` to 3'b000.
  - `buf_valid` to 0.
- Reset mid-burst: `cyc`/`stb` are low after that edge. A late `i_wb_ack` arriving in IDLE is ignored.
- All outputs are registered; there is no combinational path from `i_wb_*` or `i_ic_*` to outputs.
- Miss latency: request sampled at edge k; `cyc`/`stb` high from cycle k+1; `o_ic_valid` high the cycle after the final ack. With a zero-wait slave this is k+1+`BEATS`.
- Hit latency: 1 cycle.
- Wishbone rules:
  - `stb`, `addr` and `cti` are held stable until acked.
  - `stb` stays asserted between burst beats.
  - `o_wb_addr` advances in the cycle after each non-final ack.
  - Wait states of any length are supported.

## Structure
- Shared `procyon_wb_pkg` holds:
  - `WB_CTI_WIDTH`=3 and `WB_BTE_WIDTH`=2, replacing the per-file defines.
  - Constants `WB_CTI_CLASSIC`=3'b000, `WB_CTI_INCR`=3'b010, `WB_CTI_EOB`=3'b111.
  - `WB_BTE_LINEAR`=2'b00.
- The FSM state enum (IDLE, BUS) is local to the module.
- Single module; no sub-module. The buffer is three registers and not worth splitting out.

## Test plan
- Reset then fetch PC 0x0000_0100 with `OPTN_WB_DATA_WIDTH`=16 and the slave returning 0x1234 then 0xABCD:
  - Two beats: addr 0x100 with cti 010, then addr 0x102 with cti 111.
  - `o_ic_insn`=0xABCD1234; `o_ic_valid` pulses 1 cycle.
- Repeat fetch of 0x100 after the first completes: no `o_wb_cyc`; valid next cycle with 0xABCD1234. Holding `i_ic_en` gives valid every cycle.
- PC 0x200 miss, with the core switching to 0x300 before the ack (3 wait states):
  - No valid pulse for 0x200 and the buffer holds 0x200.
  - Next a burst for 0x300 starts after one idle cycle.
- Misaligned PC 0x0000_0106 with the 32-bit width: single classic read at 0x104, cti 000, sel 4'hF.
- Drive `n_rst`=0 during beat 1 of a burst:
  - `cyc`/`stb`/`valid` are 0 the next cycle and a stale ack is ignored.
  - After reset, a fetch of the buffered PC misses because `buf_valid` was cleared.
